// File: rtl/systolic_ctrl_pkg.sv
// Shared command-controller constants: opcodes, FSM state encoding, status bit positions.
// No logic here, so it adds no latency and has no backpressure.
package systolic_ctrl_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LOAD_A = 8'h10;
    localparam logic [7:0] OP_LOAD_B = 8'h11;
    localparam logic [7:0] OP_START  = 8'h20;
    localparam logic [7:0] OP_READ_C = 8'h30;
    localparam logic [7:0] OP_STATUS = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_READ    = 3'd4
    } state_t;

    localparam int STAT_BUSY     = 7;
    localparam int STAT_DONE     = 6;
    localparam int STAT_LOADED_B = 5;
    localparam int STAT_LOADED_A = 4;
    localparam int STAT_ERR      = 3;

endpackage

// File: rtl/systolic_rd_serializer.sv
// Result readback: prefetches result words and shifts them out LSB byte first.
// First byte 3 cycles after start, next word 3 cycles after its tx_load; paced purely by tx_load.
module systolic_rd_serializer #(
    parameter int N      = 4,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              tx_load,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [ACC_W-1:0]  res_rdata,
    output logic [7:0]        tx_byte,
    output logic              last
);

    logic [ACC_W-1:0] shreg;
    logic [1:0]       byte_idx;
    logic [1:0]       pf_cnt;

    assign tx_byte = shreg[7:0];
    assign last    = tx_load && (byte_idx == 2'd3) && (res_addr == ADDR_W'(N*N-1));

    // pf_cnt covers the address register plus the one-cycle memory read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_addr <= '0;
            shreg    <= '0;
            byte_idx <= '0;
            pf_cnt   <= '0;
        end else if (start) begin
            res_addr <= '0;
            byte_idx <= '0;
            pf_cnt   <= 2'd2;
        end else begin
            if (pf_cnt != 2'd0) begin
                pf_cnt <= pf_cnt - 2'd1;
                if (pf_cnt == 2'd1)
                    shreg <= res_rdata;
            end
            if (tx_load) begin
                if (byte_idx != 2'd3) begin
                    byte_idx <= byte_idx + 2'd1;
                    shreg    <= shreg >> 8;
                end else if (!last) begin
                    byte_idx <= '0;
                    res_addr <= res_addr + ADDR_W'(1);
                    pf_cnt   <= 2'd2;
                end
            end
        end
    end

endmodule

// File: rtl/systolic_cmd_sequencer.sv
// SPI command controller: decodes opcodes, loads operands, launches the array, reads results.
// Writes/strobes/status one cycle after the byte; readback paced by tx_load, no rx backpressure.
module systolic_cmd_sequencer
    import systolic_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_load,
    output logic [7:0]        tx_byte,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [ACC_W-1:0]  res_rdata,
    output logic              arr_start,
    input  logic              arr_busy,
    input  logic              arr_done,
    output logic              irq,
    output logic [2:0]        state_o,
    output logic [ADDR_W+2:0] data_count
);

    localparam logic [ADDR_W+2:0] LOAD_LAST = (ADDR_W+3)'(2*N*N - 1);

    state_t     state, state_nxt;
    logic       loaded_a, loaded_b, done, err;
    logic [7:0] lo_byte, tx_reg, ser_tx, stat;
    logic       load_cmd, lo_cap, wr_word, launch, stat_rd, set_err;
    logic       ser_start, ser_adv, ser_last, done_evt;

    assign state_o  = state;
    assign done_evt = (state == ST_COMPUTE) && arr_done;
    assign tx_byte  = (state == ST_READ) ? ser_tx : tx_reg;

    always_comb begin
        stat                = '0;
        stat[STAT_BUSY]     = arr_busy;
        stat[STAT_DONE]     = done | done_evt;
        stat[STAT_LOADED_B] = loaded_b;
        stat[STAT_LOADED_A] = loaded_a;
        stat[STAT_ERR]      = err;
        stat[2:0]           = state;
    end

    always_comb begin
        state_nxt = state;
        load_cmd  = 1'b0;
        lo_cap    = 1'b0;
        wr_word   = 1'b0;
        launch    = 1'b0;
        stat_rd   = 1'b0;
        set_err   = 1'b0;
        ser_start = 1'b0;
        ser_adv   = 1'b0;
        unique case (state)
            ST_IDLE: if (rx_valid) begin
                case (rx_byte)
                    OP_NOP: ;
                    OP_LOAD_A, OP_LOAD_B: begin
                        load_cmd  = 1'b1;
                        state_nxt = ST_LOAD_LO;
                    end
                    OP_START: if (loaded_a && loaded_b && !arr_busy) begin
                        launch    = 1'b1;
                        state_nxt = ST_COMPUTE;
                    end else set_err = 1'b1;
                    OP_READ_C: if (done) begin
                        ser_start = 1'b1;
                        state_nxt = ST_READ;
                    end else set_err = 1'b1;
                    OP_STATUS: stat_rd = 1'b1;
                    default:   set_err = 1'b1;
                endcase
            end
            ST_LOAD_LO: if (rx_valid) begin
                lo_cap    = 1'b1;
                state_nxt = ST_LOAD_HI;
            end
            ST_LOAD_HI: if (rx_valid) begin
                wr_word   = 1'b1;
                state_nxt = (data_count == LOAD_LAST) ? ST_IDLE : ST_LOAD_LO;
            end
            ST_COMPUTE: begin
                if (rx_valid) begin
                    if (rx_byte == OP_STATUS) stat_rd = 1'b1;
                    else                      set_err = 1'b1;
                end
                if (arr_done) state_nxt = ST_IDLE;
            end
            ST_READ: if (tx_load) begin
                ser_adv = 1'b1;
                if (ser_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // In LOAD_HI data_count is 2k+1 for word k, so its upper bits are the word index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            loaded_a   <= 1'b0;
            loaded_b   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            irq        <= 1'b0;
            lo_byte    <= '0;
            tx_reg     <= '0;
            mem_we     <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            arr_start  <= 1'b0;
            data_count <= '0;
        end else begin
            state     <= state_nxt;
            mem_we    <= wr_word;
            arr_start <= launch;
            if (load_cmd) begin
                mem_sel <= rx_byte[0];
                if (rx_byte[0]) loaded_b <= 1'b0;
                else            loaded_a <= 1'b0;
            end
            if (lo_cap) lo_byte <= rx_byte;
            if (wr_word) begin
                mem_addr  <= data_count[ADDR_W:1];
                mem_wdata <= DATA_W'({rx_byte, lo_byte});
                if (data_count == LOAD_LAST) begin
                    if (mem_sel) loaded_b <= 1'b1;
                    else         loaded_a <= 1'b1;
                end
            end
            if (state == ST_IDLE && rx_valid)
                data_count <= '0;
            else if (lo_cap || wr_word || ser_adv)
                data_count <= data_count + (ADDR_W+3)'(1);
            if (launch)        done <= 1'b0;
            else if (done_evt) done <= 1'b1;
            if (stat_rd)       irq <= 1'b0;
            else if (done_evt) irq <= 1'b1;
            if (set_err)      err <= 1'b1;
            else if (stat_rd) err <= 1'b0;
            if (stat_rd)
                tx_reg <= stat;
            else if (state == ST_READ && state_nxt == ST_IDLE)
                tx_reg <= 8'h00;
        end
    end

    systolic_rd_serializer #(.N(N), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_rd_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (ser_start),
        .tx_load   (ser_adv),
        .res_addr  (res_addr),
        .res_rdata (res_rdata),
        .tx_byte   (ser_tx),
        .last      (ser_last)
    );

endmodule

// File: doc/systolic_cmd_sequencer.md
Name: systolic_cmd_sequencer

Overview:
Command-level controller between the SPI byte slave and the systolic array datapath. It decodes opcode bytes and streams matrix A/B words into operand storage. It launches the array, tracks completion and raises irq. It then serializes the result matrix back out through the SPI transmit byte path. This is the single owner of operand and result memory ports on the SPI side.

Parameters:
N, 4, matrix dimension (N*N words per matrix)
DATA_W, 16, operand word width; sent as 2 bytes, low byte first
ACC_W, 32, result word width; sent as 4 bytes, LSB first
ADDR_W, $clog2(N*N), operand/result memory address width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_byte holds a received SPI byte
rx_byte  in  8  received byte
tx_load  in  1  one-cycle pulse: SPI slave latched tx_byte; controller advances
tx_byte  out  8  next byte to shift out
mem_we  out  1  operand write strobe (one cycle)
mem_sel  out  1  0 = matrix A, 1 = matrix B
mem_addr  out  ADDR_W  operand write address
mem_wdata  out  DATA_W  operand write data
res_addr  out  ADDR_W  result read address
res_rdata  in  ACC_W  result data; valid 1 cycle after res_addr changes
arr_start  out  1  one-cycle launch pulse to array
arr_busy  in  1  array computing
arr_done  in  1  one-cycle completion pulse
irq  out  1  level; set on arr_done, cleared by status read
state_o  out  3  current FSM state (debug)
data_count  out  ADDR_W+3  bytes consumed/produced in current command

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, all outputs 0, tx_byte 0x00; flags loaded_a, loaded_b, done, err all 0.
- Opcodes (IDLE only): 0x00 NOP; 0x10 LOAD_A; 0x11 LOAD_B; 0x20 START; 0x30 READ_C; 0x40 STATUS. Any other opcode sets err and stays in IDLE.
- States: IDLE=0, LOAD_LO=1, LOAD_HI=2, COMPUTE=3, READ=4. Command state persists across cs_n frames; there is no frame-based abort.
- LOAD_A/LOAD_B: latch mem_sel, clear data_count, clear the matching loaded flag, go to LOAD_LO.
  - LOAD_LO: rx byte latched as low byte, go to LOAD_HI.
  - LOAD_HI: on rx byte, mem_we=1 on the next cycle with mem_addr=word index and mem_wdata={hi,lo}. Go to LOAD_LO.
  - After word N*N-1 is written: set the loaded flag and return to IDLE.
  - Every rx byte increments data_count. In LOAD states all bytes are data; no opcode decode.
- START: if loaded_a & loaded_b & !arr_busy, then arr_start=1 for exactly one cycle on the next cycle, clear done, go to COMPUTE. Otherwise set err and stay in IDLE.
- COMPUTE: 0x40 is serviced. Any other rx byte is ignored and sets err.
  - On arr_done: set done and irq, go to IDLE.
  - arr_done and rx 0x40 in the same cycle: the status byte reports done=1, and irq ends 0 because the read clears it.
- STATUS (IDLE or COMPUTE): on the next cycle tx_byte = {arr_busy, done, loaded_b, loaded_a, err, state[2:0]}, sampled at decode. Clears irq and err.
- READ_C: requires done; otherwise set err and stay in IDLE.
  - Entry: res_addr=0, and the word is captured into a shift register 2 cycles later. tx_byte = byte 0 of word 0.
  - Each tx_load advances to the next byte. After byte 3, res_addr increments and the next word is prefetched. tx_byte is valid ≤3 cycles after tx_load; the SPI slave guarantees ≥8 clk between tx_load pulses.
  - After N*N*4 tx_load pulses: go to IDLE with tx_byte=0x00.
- tx_load outside READ: ignored, tx_byte holds.
- Reset mid-operation: immediate return to reset values. A partially loaded matrix is not marked loaded, and arr_start is never emitted.
- data_count wraps never: its width covers N*N*4.

Decomposition:
- Package systolic_ctrl_pkg holds the opcode constants, the state encoding, and status bit positions; the testbench shares it.
- One sub-module, systolic_rd_serializer, holds the result prefetch, word shift register and byte counter. Its interface is start, tx_load, res_addr, res_rdata, tx_byte and last.

Test Plan:
- Reset, then 0x40 -> tx_byte=0x00; state_o=0; no mem_we, no arr_start.
- 0x10 followed by 32 bytes (word k = 0x0100+k, low byte first) -> 16 mem_we pulses with mem_sel=0, addr 0..15, wdata 0x0100..0x010F. Then state IDLE, status bit4 (loaded_a)=1.
- 0x20 with only A loaded -> no arr_start, status err bit3=1. A second 0x40 then reads err=0.
- Load A and B, send 0x20 -> single arr_start pulse, state 3. Model arr_done after 40 clk -> irq=1, state 0. 0x40 -> done bit6=1, irq=0.
- 0x30 with model result word k = 0xA0000000+k -> 64 tx_load yield bytes k,00,00,A0 per word in order. Then state IDLE.
- Edge cases, each a separate run:
  - rst_n low after 5 bytes of LOAD_B -> loaded_b=0, state 0.
  - arr_done coincident with rx 0x40 -> status done=1, irq=0.
